// File: rtl/sync_load_clear_reg.sv
// Datapath holding register for operands and status words.
// Sync active-low clear beats sync load; async reset is power-on only.
`timescale 1ns/1ps

module sync_load_clear_reg #(
  parameter int unsigned          WIDTH     = 8,
  parameter logic [WIDTH-1:0]     RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Qout
);

  logic [WIDTH-1:0] q_nxt;
  logic             do_clr;
  logic             do_ld;

  assign do_clr = ~clear;
  assign do_ld  = clear & load;

  // Next-value select; D is only looked at when loading, so X on an
  // unused D never reaches the register.
  always_comb begin
    q_nxt = Qout;
    unique case (1'b1)
      do_clr:  q_nxt = RESET_VAL;
      do_ld:   q_nxt = D;
      default: q_nxt = Qout;
    endcase
  end

  // State register; reset acts immediately, everything else on the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) Qout <= RESET_VAL;
    else        Qout <= q_nxt;
  end

endmodule

// File: tb/tb_sync_load_clear_reg.sv
// Scoreboard bench for sync_load_clear_reg.
// Expected values come from a bench-side model pushed to a queue.
`timescale 1ns/1ps

module tb_sync_load_clear_reg;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b1;
  logic       load = 1'b0;
  logic [7:0] D = 8'h00;
  logic [7:0] Qout;

  int         vectors = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  logic [7:0] model = 8'h00;
  logic [7:0] exp_q;

  sync_load_clear_reg #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .clear(clear),
    .load(load),
    .D(D),
    .Qout(Qout)
  );

  always #2 clk = ~clk;

  // Drive one cycle of inputs, predict, push, then wait past the edge.
  task automatic apply(input logic c, input logic l,
                       input logic [7:0] d);
    clear = c;
    load  = l;
    D     = d;
    if (!c)     model = 8'h00;
    else if (l) model = d;
    sb.push_back(model);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    apply(1'b1, 1'b1, 8'hA5);
    exp_q = sb.pop_front();
    vectors++;
    if (Qout !== exp_q) begin
      errors++;
      $display("FAIL reset_preload: Qout=%h want %h", Qout, exp_q);
    end
    // Pending load of 8'hCC is set up, then reset lands mid-cycle.
    clear = 1'b1;
    load  = 1'b1;
    D     = 8'hCC;
    #0.5;
    rst_n = 1'b0;
    model = 8'h00;
    #0.5;
    vectors++;
    if (Qout !== 8'h00) begin
      errors++;
      $display("FAIL reset_async: Qout=%h want 00", Qout);
    end
    for (int i = 0; i < 3; i++) begin
      D = 8'hFF;
      @(posedge clk);
      #1;
      vectors++;
      if (Qout !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold%0d: Qout=%h want 00", i, Qout);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    logic [7:0] pat [2];
    pat[0] = 8'h00;
    pat[1] = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      apply(1'b1, 1'b1, pat[i]);
      exp_q = sb.pop_front();
      vectors++;
      if (Qout !== exp_q) begin
        errors++;
        $display("FAIL load%0d: Qout=%h want %h", i, Qout, exp_q);
      end
    end
  endtask

  task automatic test_clear_beats_load();
    for (int i = 0; i < 4; i++) begin
      apply(1'b0, 1'b1, 8'h80);
      exp_q = sb.pop_front();
      vectors++;
      if (Qout !== exp_q) begin
        errors++;
        $display("FAIL clr_vs_ld%0d: Qout=%h want %h", i, Qout, exp_q);
      end
    end
  endtask

  task automatic test_resume();
    apply(1'b1, 1'b1, 8'h80);
    exp_q = sb.pop_front();
    vectors++;
    if (Qout !== exp_q) begin
      errors++;
      $display("FAIL resume: Qout=%h want %h", Qout, exp_q);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, 1'b0, 8'h45);
      exp_q = sb.pop_front();
      vectors++;
      if (Qout !== exp_q) begin
        errors++;
        $display("FAIL hold%0d: Qout=%h want %h", i, Qout, exp_q);
      end
    end
  endtask

  task automatic test_async();
    // Wiggle controls between edges; nothing may move until the edge.
    clear = 1'b0;
    load  = 1'b1;
    D     = 8'h33;
    #0.5;
    vectors++;
    if (Qout !== model) begin
      errors++;
      $display("FAIL async_a: Qout=%h want %h", Qout, model);
    end
    clear = 1'b1;
    #0.5;
    vectors++;
    if (Qout !== model) begin
      errors++;
      $display("FAIL async_b: Qout=%h want %h", Qout, model);
    end
    load = 1'b0;
    D    = 8'bx;
    #0.5;
    vectors++;
    if (Qout !== model) begin
      errors++;
      $display("FAIL async_c: Qout=%h want %h", Qout, model);
    end
    // X on D must be blocked by hold and by clear.
    apply(1'b1, 1'b0, 8'bx);
    exp_q = sb.pop_front();
    vectors++;
    if (Qout !== exp_q) begin
      errors++;
      $display("FAIL x_hold: Qout=%h want %h", Qout, exp_q);
    end
    apply(1'b0, 1'b0, 8'bx);
    exp_q = sb.pop_front();
    vectors++;
    if (Qout !== exp_q) begin
      errors++;
      $display("FAIL x_clear: Qout=%h want %h", Qout, exp_q);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    for (int i = 0; i < 12; i++) begin
      d = 8'($urandom_range(0, 255));
      apply(1'b1, 1'b1, d);
      exp_q = sb.pop_front();
      vectors++;
      if (Qout !== exp_q) begin
        errors++;
        $display("FAIL b2b%0d: Qout=%h want %h", i, Qout, exp_q);
      end
    end
    for (int i = 0; i < 8; i++) begin
      d = 8'($urandom_range(0, 255));
      apply(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), d);
      exp_q = sb.pop_front();
      vectors++;
      if (Qout !== exp_q) begin
        errors++;
        $display("FAIL mix%0d: Qout=%h want %h", i, Qout, exp_q);
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (Qout !== 8'h00) begin
      errors++;
      $display("FAIL por: Qout=%h want 00", Qout);
    end
    rst_n = 1'b1;
    test_reset();
    test_load();
    test_clear_beats_load();
    test_resume();
    test_hold();
    test_async();
    test_back_to_back();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: left=%0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
